// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode type, opcode constants and datapath width.
package alu_pkg;
    typedef logic [2:0] alu_op_t;
    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;
    localparam int ALU_WIDTH = 32;
endpackage

// File: rtl/alu_flopr_mux2_if.sv
// alu_flopr_mux2_if: bundles the ALU, register and mux signals of the primitive wrapper.
interface alu_flopr_mux2_if import alu_pkg::*; #(parameter int WIDTH = 32) ();
    logic                 en;
    logic [WIDTH-1:0]     d;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     d0;
    logic [WIDTH-1:0]     d1;
    logic                 s;
    logic [WIDTH-1:0]     m_y;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    alu_op_t              f;
    logic                 cout;
    logic                 zero;
    logic [ALU_WIDTH-1:0] y;
    modport master (output en, d, d0, d1, s, a, b, f, input q, m_y, cout, zero, y);
    modport slave  (input en, d, d0, d1, s, a, b, f, output q, m_y, cout, zero, y);
endinterface

// File: rtl/alu.sv
// alu: combinational 32-bit MIPS ALU; ALU_OVF_SLT_EN makes SLT a true signed compare.
module alu import alu_pkg::*; (
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  alu_op_t              f,
    output logic                 cout,
    output logic                 zero,
    output logic [ALU_WIDTH-1:0] y
);
    logic [ALU_WIDTH-1:0] bb;
    logic [ALU_WIDTH-1:0] sum;
    logic                 lt;
    assign bb = f[2] ? ~b : b;
    alu_adder u_adder (.a(a), .b(bb), .cin(f[2]), .sum(sum), .cout(cout));
`ifdef ALU_OVF_SLT_EN
    assign lt = sum[31] ^ ((a[31] == bb[31]) & (sum[31] != a[31]));
`else
    assign lt = sum[31];
`endif
    // logic ops use bb so the f[2] codes give and-not / or-not for free
    always_comb begin
        y = (f[1:0] == 2'b00) ? a & bb :
            (f[1:0] == 2'b01) ? a | bb :
            (f == ALU_ADD || f == ALU_SUB) ? sum :
            (f == ALU_SLT) ? {{(ALU_WIDTH-1){1'b0}}, lt} : '0;
        zero = (y == '0);
    end
endmodule

// File: rtl/alu_adder.sv
// alu_adder: 32-bit a + b + cin with carry out.
module alu_adder import alu_pkg::*; (
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [ALU_WIDTH-1:0] sum,
    output logic                 cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, cin};
endmodule

// File: rtl/flopr.sv
// flopr: enable-gated register with asynchronous active-high reset to RESET_VALUE.
module flopr #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d, q_q;
    // load d when enabled, otherwise hold
    always_comb q_d = en ? d : q_q;
    // reset wins over any clock edge
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= RESET_VALUE;
        else       q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/mux2.sv
// mux2: combinational 2:1 select.
module mux2 #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/alu_flopr_mux2.sv
// alu_flopr_mux2: exposes alu, flopr and mux2 side by side (ALU_OVF_SLT_EN selects signed SLT).
module alu_flopr_mux2 import alu_pkg::*; #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic          clk,
    input logic          reset,
    alu_flopr_mux2_if.slave bus
);
    alu u_alu (.a(bus.a), .b(bus.b), .f(bus.f), .cout(bus.cout), .zero(bus.zero), .y(bus.y));
    flopr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_flopr (
        .clk(clk), .reset(reset), .en(bus.en), .d(bus.d), .q(bus.q)
    );
    mux2 #(.WIDTH(WIDTH)) u_mux2 (.d0(bus.d0), .d1(bus.d1), .s(bus.s), .y(bus.m_y));
endmodule

// File: tb/tb_alu_flopr_mux2.sv
// tb_alu_flopr_mux2: random and directed checks of the wrapper against a behavioural model.
module tb_alu_flopr_mux2;
    import alu_pkg::*;
    localparam logic [31:0] RV = 32'h0040_0000;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q;
    logic [33:0] ref_v;

    alu_flopr_mux2_if #(.WIDTH(32)) bus();
    alu_flopr_mux2 #(.WIDTH(32), .RESET_VALUE(RV)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // returns {cout, zero, y} from the arithmetic meaning of each opcode
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [31:0] r;
        logic [31:0] diff;
        logic lt, c;
        diff = a - b;
`ifdef ALU_OVF_SLT_EN
        lt = $signed(a) < $signed(b);
`else
        lt = diff[31];
`endif
        case (f)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a + b;
            3'b110: r = diff;
            3'b111: r = {31'b0, lt};
            3'b100: r = a & ~b;
            3'b101: r = a | ~b;
            default: r = 32'b0;
        endcase
        c = f[2] ? (a >= b) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
        return {c, (r == 32'b0), r};
    endfunction

    // every falling edge: all outputs against the model
    always @(negedge clk) begin
        ref_v = alu_ref(bus.a, bus.b, bus.f);
        chk("alu_y", bus.y, ref_v[31:0]);
        chk("alu_zero", {31'b0, bus.zero}, {31'b0, ref_v[32]});
        chk("alu_cout", {31'b0, bus.cout}, {31'b0, ref_v[33]});
        chk("mux_y", bus.m_y, bus.s ? bus.d1 : bus.d0);
        chk("flop_q", bus.q, exp_q);
    end

    task automatic tick();
        @(posedge clk);
        if (!reset && bus.en) exp_q = bus.d;
        #2;
    endtask

    task automatic lit(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic [31:0] ey, input logic ez, input logic ec);
        logic [33:0] m;
        tick();
        bus.a = a; bus.b = b; bus.f = f;
        #1;
        m = alu_ref(a, b, f);
        chk("lit_y", bus.y, ey);
        chk("lit_zero", {31'b0, bus.zero}, {31'b0, ez});
        chk("lit_cout", {31'b0, bus.cout}, {31'b0, ec});
        chk("model_y", m[31:0], ey);
        chk("model_cout", {31'b0, m[33]}, {31'b0, ec});
    endtask

    initial begin
        bus.a = '0; bus.b = '0; bus.f = ALU_AND;
        bus.d0 = '0; bus.d1 = '0; bus.s = 1'b0;
        bus.en = 1'b1; bus.d = 32'h1234;
        exp_q = RV;
        #1 reset = 1'b1;
        lit(32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1'b0);
        lit(32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, 1'b1);
        lit(32'h1234, 32'h1234, ALU_SUB, 32'd0, 1'b1, 1'b1);
        lit(32'hF0F0, 32'h0FF0, ALU_AND, 32'h00F0, 1'b0, 1'b0);
        lit(32'hF0F0, 32'h0FF0, ALU_OR, 32'hFFF0, 1'b0, 1'b0);
        lit(32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1, 1'b0, 1'b1);
`ifdef ALU_OVF_SLT_EN
        lit(32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'd1, 1'b0, 1'b1);
`else
        lit(32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'd0, 1'b1, 1'b1);
`endif
        lit(32'h1234, 32'h5678, 3'b011, 32'd0, 1'b1, 1'b0);
        lit(32'hFF00, 32'h0F00, 3'b100, 32'hF000, 1'b0, 1'b1);
        tick();
        bus.d0 = 32'hAAAA; bus.d1 = 32'h5555; bus.s = 1'b0;
        #1 chk("mux_s0", bus.m_y, 32'hAAAA);
        bus.s = 1'b1;
        #1 chk("mux_s1", bus.m_y, 32'h5555);
        chk("q_reset_held", bus.q, RV);
        reset = 1'b0; bus.en = 1'b1; bus.d = 32'h0040_0004;
        tick();
        chk("q_load", bus.q, 32'h0040_0004);
        bus.en = 1'b0; bus.d = 32'hDEAD;
        tick();
        chk("q_hold", bus.q, 32'h0040_0004);
        reset = 1'b1; exp_q = RV;
        #1 chk("q_async", bus.q, RV);
        bus.en = 1'b1; bus.d = 32'h55;
        tick();
        chk("q_edge_ignored", bus.q, RV);
        reset = 1'b0;
        tick();
        chk("q_first_edge", bus.q, 32'h55);
        repeat (400) begin
            tick();
            case ($urandom_range(4))
                0: bus.a = 32'h8000_0000;
                1: bus.a = 32'h7FFF_FFFF;
                2: bus.a = 32'hFFFF_FFFF;
                default: bus.a = $urandom;
            endcase
            case ($urandom_range(4))
                0: bus.b = 32'h8000_0000;
                1: bus.b = 32'h7FFF_FFFF;
                2: bus.b = bus.a;
                default: bus.b = $urandom;
            endcase
            bus.f = 3'($urandom_range(7));
            bus.d0 = $urandom; bus.d1 = $urandom; bus.s = 1'($urandom_range(1));
            bus.en = 1'($urandom_range(1)); bus.d = $urandom;
            reset = ($urandom_range(15) == 0);
            if (reset) exp_q = RV;
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
